// File: rtl/ws_pulse_decoder.sv
// ws_pulse_decoder: decodes a single-wire NRZ pulse-width LED stream into
// 24-bit words. A long high pulse (>= BIT_THRESH cycles) is a 1 and a short
// one is a 0. The first bit received lands in bit 23. A low period of
// RESET_CYCLES ends the frame and reports how many words it held.
// Optional feature: define WS_DECODER_GLITCH_FILTER_EN to ignore high pulses
// shorter than MIN_HIGH cycles.
module ws_pulse_decoder #(
  parameter int BIT_THRESH   = 30,
  parameter int RESET_CYCLES = 2500,
  parameter int MIN_HIGH     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_stripe_pin,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        frame_end,
  output logic [7:0]  frame_pixels,
  output logic        err
);

  localparam logic [15:0] RST_LIM = 16'(RESET_CYCLES);
  localparam logic [15:0] THR     = 16'(BIT_THRESH);
`ifdef WS_DECODER_GLITCH_FILTER_EN
  localparam logic [15:0] MIN_LIM = 16'(MIN_HIGH);
`endif

  // The 16-bit duration counters only work if the frame limit fits below saturation.
  if (RESET_CYCLES >= 65535 || RESET_CYCLES < 1 || MIN_HIGH < 1) begin : g_param_check
    $error("ws_pulse_decoder: RESET_CYCLES must be 1..65534 and MIN_HIGH >= 1");
  end

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        pin_p0, pin_p1, pin_p2;
  logic        rise, fall;
  state_t      state;
`ifdef WS_DECODER_GLITCH_FILTER_EN
  state_t      ret_state;
`endif
  logic [15:0] high_cnt, low_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] shreg;
  logic [7:0]  pix_cnt;
  logic        bit_val;
  logic [23:0] next_word;
  logic [23:0] word_p2;
  logic [7:0]  pix_p2;
  logic        vld_p2, fend_p2, err_p2;

  assign rise      = pin_p1 & ~pin_p2;
  assign fall      = ~pin_p1 & pin_p2;
  assign bit_val   = (high_cnt >= THR);
  assign next_word = {shreg[22:0], bit_val};

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_p0 <= 1'b0;
      pin_p1 <= 1'b0;
      pin_p2 <= 1'b0;
    end else begin
      pin_p0 <= led_stripe_pin;
      pin_p1 <= pin_p0;
      pin_p2 <= pin_p1;
    end
  end

  // ---- stage p2: pulse-width FSM, bit assembly and frame bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
`ifdef WS_DECODER_GLITCH_FILTER_EN
      ret_state <= IDLE;
`endif
      high_cnt <= '0;
      low_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pix_cnt  <= '0;
      word_p2  <= '0;
      pix_p2   <= '0;
      vld_p2   <= 1'b0;
      fend_p2  <= 1'b0;
      err_p2   <= 1'b0;
    end else begin
      vld_p2  <= 1'b0;
      fend_p2 <= 1'b0;
      err_p2  <= 1'b0;
      case (state)
        SYNC: begin
          if (pin_p1) begin
            low_cnt <= '0;
          end else if (sat_inc16(low_cnt) >= RST_LIM) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= sat_inc16(low_cnt);
          end
        end
        IDLE: begin
          if (rise) begin
            high_cnt <= 16'd1;
            state    <= HIGH;
`ifdef WS_DECODER_GLITCH_FILTER_EN
            ret_state <= IDLE;
            low_cnt   <= sat_inc16(low_cnt);
`endif
          end
        end
        HIGH: begin
          if (fall) begin
`ifdef WS_DECODER_GLITCH_FILTER_EN
            if (high_cnt < MIN_LIM) begin
              // Too short to be a bit: resume the low period it interrupted
              state   <= ret_state;
              low_cnt <= sat_inc16(low_cnt);
            end else
`endif
            begin
              shreg   <= next_word;
              low_cnt <= 16'd1;
              state   <= LOW;
              if (bit_cnt == 5'd23) begin
                word_p2 <= next_word;
                vld_p2  <= 1'b1;
                bit_cnt <= '0;
                pix_cnt <= sat_inc8(pix_cnt);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else if (sat_inc16(high_cnt) >= RST_LIM) begin
            // Line stuck high: drop everything and resynchronise
            err_p2   <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            high_cnt <= '0;
            low_cnt  <= '0;
            state    <= SYNC;
          end else begin
            high_cnt <= sat_inc16(high_cnt);
`ifdef WS_DECODER_GLITCH_FILTER_EN
            low_cnt  <= sat_inc16(low_cnt);
`endif
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt <= 16'd1;
            state    <= HIGH;
`ifdef WS_DECODER_GLITCH_FILTER_EN
            ret_state <= LOW;
            low_cnt   <= sat_inc16(low_cnt);
`endif
          end else if (sat_inc16(low_cnt) >= RST_LIM) begin
            // Latch gap: close the frame, flag a dangling partial word
            fend_p2 <= 1'b1;
            err_p2  <= (bit_cnt != 5'd0);
            pix_p2  <= pix_cnt;
            pix_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= sat_inc16(low_cnt);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // ---- stage p3: registered outputs; data_out and frame_pixels hold between updates ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      frame_pixels <= '0;
      data_valid   <= 1'b0;
      frame_end    <= 1'b0;
      err          <= 1'b0;
    end else begin
      data_valid <= vld_p2;
      frame_end  <= fend_p2;
      err        <= err_p2;
      if (vld_p2)  data_out     <= word_p2;
      if (fend_p2) frame_pixels <= pix_p2;
    end
  end

endmodule

// File: tb/tb_ws_pulse_decoder.sv
// Bench for ws_pulse_decoder: table-driven frames plus hand-written corner
// sequences, with a scoreboard of expected output events.
module tb_ws_pulse_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        led_stripe_pin;
  logic [23:0] data_out;
  logic        data_valid;
  logic        frame_end;
  logic [7:0]  frame_pixels;
  logic        err;

  ws_pulse_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .led_stripe_pin (led_stripe_pin),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .frame_end      (frame_end),
    .frame_pixels   (frame_pixels),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dv;
    logic [23:0] data;
    bit          fe;
    logic [7:0]  pix;
    bit          er;
  } exp_t;

  typedef struct {
    int          nw;
    logic [23:0] w0, w1, w2;
    int          nb;
    logic [23:0] pw;
    logic [7:0]  pix;
    bit          er;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fall = 0;
  bit          check_lat = 1'b1;
  bit          mon_en = 1'b0;
  logic [23:0] last_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (mon_en && (data_valid || frame_end || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual dv=%0b fe=%0b err=%0b required none",
                 data_valid, frame_end, err);
      end else begin
        mon_e = sb.pop_front();
        chk("data_valid", {31'd0, data_valid}, {31'd0, mon_e.dv});
        chk("frame_end", {31'd0, frame_end}, {31'd0, mon_e.fe});
        chk("err", {31'd0, err}, {31'd0, mon_e.er});
        if (mon_e.dv) begin
          chk("data_out", {8'd0, data_out}, {8'd0, mon_e.data});
          last_word = mon_e.data;
          if (check_lat) chk("latency", cyc - last_fall, 3);
        end
        if (mon_e.fe) begin
          chk("frame_pixels", {24'd0, frame_pixels}, {24'd0, mon_e.pix});
          chk("data_out_hold", {8'd0, data_out}, {8'd0, last_word});
        end
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int h, input int l);
    led_stripe_pin = 1'b1;
    ticks(h);
    led_stripe_pin = 1'b0;
    last_fall = cyc + 1;
    ticks(l);
  endtask

  task automatic send_bit(input bit b);
    if (b) send_pulse(40, 22);
    else   send_pulse(20, 42);
  endtask

  task automatic send_word(input logic [23:0] w, input bit push);
    for (int i = 23; i >= 0; i--) begin
      if (i == 0 && push) sb.push_back('{1'b1, w, 1'b0, 8'd0, 1'b0});
      send_bit(w[i]);
    end
  endtask

  task automatic push_frame(input logic [7:0] p, input bit e);
    sb.push_back('{1'b0, 24'd0, 1'b1, p, e});
  endtask

  vec_t        vt[4];
  logic [23:0] w;

  initial begin
    vt[0] = '{1, 24'hA5C33C, 24'h0,      24'h0,      0, 24'h0,      8'd1, 1'b0};
    vt[1] = '{3, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0, 24'h0,      8'd3, 1'b0};
    vt[2] = '{0, 24'h0,      24'h0,      24'h0,      10, 24'hABCDEF, 8'd0, 1'b1};
    vt[3] = '{2, 24'h123456, 24'h654321, 24'h0,      5, 24'hF0F0F0, 8'd2, 1'b1};

    rst = 1'b1;
    led_stripe_pin = 1'b0;
    ticks(3);
    chk("reset_data_out", {8'd0, data_out}, 32'd0);
    chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_frame_end", {31'd0, frame_end}, 32'd0);
    chk("reset_frame_pixels", {24'd0, frame_pixels}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    ticks(2505);

    // Table-driven frames: whole words, then an optional partial word, then latch
    for (int v = 0; v < 4; v++) begin
      if (vt[v].nw > 0) send_word(vt[v].w0, 1'b1);
      if (vt[v].nw > 1) send_word(vt[v].w1, 1'b1);
      if (vt[v].nw > 2) send_word(vt[v].w2, 1'b1);
      for (int b = 0; b < vt[v].nb; b++) send_bit(vt[v].pw[23 - b]);
      push_frame(vt[v].pix, vt[v].er);
      ticks(2510);
    end

    // Short spike inside the low gap after the first bit
    w = 24'hA5C33C;
    send_pulse(40, 10);
    send_pulse(2, 10);
`ifdef WS_DECODER_GLITCH_FILTER_EN
    for (int i = 22; i >= 0; i--) begin
      if (i == 0) sb.push_back('{1'b1, w, 1'b0, 8'd0, 1'b0});
      send_bit(w[i]);
    end
    push_frame(8'd1, 1'b0);
`else
    for (int i = 22; i >= 0; i--) begin
      if (i == 1) sb.push_back('{1'b1, {w[23], 1'b0, w[22:1]}, 1'b0, 8'd0, 1'b0});
      send_bit(w[i]);
    end
    push_frame(8'd1, 1'b1);
`endif
    ticks(2510);

    // Line stuck high mid-word, then a word too early (ignored), then recovery
    w = 24'h123456;
    for (int i = 23; i > 18; i--) send_bit(w[i]);
    sb.push_back('{1'b0, 24'd0, 1'b0, 8'd0, 1'b1});
    led_stripe_pin = 1'b1;
    ticks(2600);
    led_stripe_pin = 1'b0;
    ticks(100);
    send_word(24'h0F0F0F, 1'b0);
    ticks(2510);
    send_word(24'h123456, 1'b1);
    push_frame(8'd1, 1'b0);
    ticks(2510);

    // Reset in the middle of a word
    w = 24'hC0FFEE;
    for (int i = 23; i > 11; i--) send_bit(w[i]);
    rst = 1'b1;
    ticks(2);
    chk("midrst_data_out", {8'd0, data_out}, 32'd0);
    chk("midrst_frame_pixels", {24'd0, frame_pixels}, 32'd0);
    last_word = '0;
    rst = 1'b0;
    ticks(2505);
    send_word(24'h5A5A5A, 1'b1);
    push_frame(8'd1, 1'b0);
    ticks(2510);

    // Pixel counter saturation: 257 fast all-zero words
    check_lat = 1'b0;
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 24; i++) begin
        if (i == 23) sb.push_back('{1'b1, 24'd0, 1'b0, 8'd0, 1'b0});
        send_pulse(2, 2);
      end
    end
    push_frame(8'd255, 1'b0);
    ticks(2510);

    ticks(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
